// File: rtl/money_field_renderer.sv
// rtl/money_field_renderer.sv - per-frame double-dabble conversion of money fields and font ROM addressing
// Optional feature macro: MONEY_LEADING_ZERO_BLANK_EN (render leading zero digits as spaces)
module money_field_renderer #(
   parameter int NUM_FIELDS = 4,
   parameter int VALUE_W    = 11,
   parameter int DIGITS     = 4
) (
   input  logic                                Clk,
   input  logic                                Reset_n,
   input  logic                                frame_start,
   input  logic [NUM_FIELDS-1:0][VALUE_W-1:0]  values,
   input  logic [NUM_FIELDS-1:0][9:0]          field_x,
   input  logic [NUM_FIELDS-1:0][9:0]          field_y,
   input  logic [9:0]                          DrawX,
   input  logic [9:0]                          DrawY,
   input  logic [7:0]                          font_data,
   output logic [10:0]                         font_address,
   output logic                                text_on,
   output logic                                busy,
   output logic                                digits_valid,
   output logic                                overrun
);
   localparam int BCD_W   = DIGITS * 4;
   localparam int FW      = (DIGITS + 1) * 8;
   localparam int CW      = $clog2(FW);
   localparam int CNT_W   = $clog2(VALUE_W + 1);
   localparam int IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int MAX_VAL = 10 ** DIGITS - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_SNAP, S_LOAD, S_SHIFT, S_COMMIT} state_t;

   state_t state, next_state;

   logic [VALUE_W-1:0]       shadow  [NUM_FIELDS];
   logic [BCD_W-1:0]         staging [NUM_FIELDS];
   logic [BCD_W-1:0]         disp    [NUM_FIELDS];
   logic [BCD_W-1:0]         bcd;
   logic [BCD_W-1:0]         bcd_adj;
   logic [VALUE_W-1:0]       bin;
   logic [BCD_W+VALUE_W-1:0] shift_all;
   logic [CNT_W-1:0]         bit_cnt;
   logic [IDX_W-1:0]         idx;

   logic [10:0]      dx, dy;
   logic             hit, hit_d;
   logic [BCD_W-1:0] sel_bcd;
   logic [CW-1:0]    sel_dx;
   logic [3:0]       sel_row;
   logic [6:0]       code;
   logic [2:0]       col_d;

   // Character code for glyph slot k: 0 is the dollar sign, 1..DIGITS are digits MSD first.
   function automatic logic [6:0] glyph_code(input logic [BCD_W-1:0] digs, input int k);
      logic [3:0] d;
`ifdef MONEY_LEADING_ZERO_BLANK_EN
      logic lead;
`endif
      d = 4'd0;
      glyph_code = 7'd36;
      if (k > 0) begin
         d = digs[(DIGITS-k)*4 +: 4];
         glyph_code = 7'd48 + 7'(d);
`ifdef MONEY_LEADING_ZERO_BLANK_EN
         lead = 1'b1;
         for (int j = 1; j <= DIGITS; j++)
            if (j <= k && digs[(DIGITS-j)*4 +: 4] != 4'd0) lead = 1'b0;
         if (lead && k < DIGITS) glyph_code = 7'd32;
`endif
      end
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (frame_start) next_state = S_SNAP;
         S_SNAP:   next_state = S_LOAD;
         S_LOAD:   next_state = S_SHIFT;
         S_SHIFT:  if (bit_cnt == CNT_W'(1)) next_state = (idx == LAST_IDX) ? S_COMMIT : S_LOAD;
         S_COMMIT: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   assign busy    = (state != S_IDLE);
   assign overrun = frame_start & busy;

   always_comb begin
      bcd_adj = '0;
      for (int n = 0; n < DIGITS; n++)
         bcd_adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? bcd[n*4 +: 4] + 4'd3 : bcd[n*4 +: 4];
   end

   assign shift_all = {bcd_adj, bin} << 1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_FIELDS; i++) begin
            shadow[i]  <= '0;
            staging[i] <= '0;
            disp[i]    <= '0;
         end
         bcd          <= '0;
         bin          <= '0;
         bit_cnt      <= '0;
         idx          <= '0;
         digits_valid <= 1'b0;
      end else begin
         case (state)
            S_SNAP: begin
               for (int i = 0; i < NUM_FIELDS; i++)
                  shadow[i] <= (int'(values[i]) > MAX_VAL) ? VALUE_W'(MAX_VAL) : values[i];
               idx <= '0;
            end
            S_LOAD: begin
               bcd     <= '0;
               bin     <= shadow[idx];
               bit_cnt <= CNT_W'(VALUE_W);
            end
            S_SHIFT: begin
               {bcd, bin} <= shift_all;
               bit_cnt    <= bit_cnt - 1'b1;
               if (bit_cnt == CNT_W'(1)) begin
                  staging[idx] <= shift_all[BCD_W+VALUE_W-1:VALUE_W];
                  if (idx != LAST_IDX) idx <= idx + 1'b1;
               end
            end
            S_COMMIT: begin
               for (int i = 0; i < NUM_FIELDS; i++) disp[i] <= staging[i];
               digits_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // 11-bit differences: a pixel left of or above a field wraps to a large value and misses.
   always_comb begin
      hit     = 1'b0;
      sel_bcd = '0;
      sel_dx  = '0;
      sel_row = '0;
      dx      = '0;
      dy      = '0;
      for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
         dx = {1'b0, DrawX} - {1'b0, field_x[i]};
         dy = {1'b0, DrawY} - {1'b0, field_y[i]};
         if (dx < 11'(FW) && dy < 11'd16) begin
            hit     = 1'b1;
            sel_bcd = disp[i];
            sel_dx  = dx[CW-1:0];
            sel_row = dy[3:0];
         end
      end
   end

   assign code         = hit ? glyph_code(sel_bcd, int'(sel_dx[CW-1:3])) : 7'd32;
   assign font_address = Reset_n ? {code, sel_row} : 11'd0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hit_d <= 1'b0;
         col_d <= 3'd0;
      end else begin
         hit_d <= hit;
         col_d <= sel_dx[2:0];
      end
   end

   assign text_on = hit_d & font_data[3'd7 - col_d];

endmodule

// File: tb/tb_money_field_renderer.sv
// tb/tb_money_field_renderer.sv - randomized bench with decimal reference model for money_field_renderer
module tb_money_field_renderer;
   localparam int NF    = 4;
   localparam int VW    = 11;
   localparam int VW14  = 14;
   localparam int DG    = 4;
   localparam int LAT   = 1 + NF * (VW + 1) + 1;
   localparam int LAT14 = 1 + NF * (VW14 + 1) + 1;
`ifdef MONEY_LEADING_ZERO_BLANK_EN
   localparam int ZC = 32;
`else
   localparam int ZC = 48;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n, frame_start;
   logic [NF-1:0][VW-1:0]   values;
   logic [NF-1:0][VW14-1:0] values14;
   logic [NF-1:0][9:0]      field_x, field_y;
   logic [9:0]             draw_x, draw_y;
   logic [7:0]             font_data;
   logic [10:0]            font_address, font_address_14;
   logic                   text_on, busy, digits_valid, overrun;
   logic                   text_on_14, busy_14, digits_valid_14, overrun_14;

   money_field_renderer dut (
      .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .values(values),
      .field_x(field_x), .field_y(field_y), .DrawX(draw_x), .DrawY(draw_y),
      .font_data(font_data), .font_address(font_address), .text_on(text_on),
      .busy(busy), .digits_valid(digits_valid), .overrun(overrun)
   );

   money_field_renderer #(.NUM_FIELDS(NF), .VALUE_W(VW14), .DIGITS(DG)) dut14 (
      .Clk(clk), .Reset_n(rst_n), .frame_start(frame_start), .values(values14),
      .field_x(field_x), .field_y(field_y), .DrawX(draw_x), .DrawY(draw_y),
      .font_data(font_data), .font_address(font_address_14), .text_on(text_on_14),
      .busy(busy_14), .digits_valid(digits_valid_14), .overrun(overrun_14)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: displayed amounts as plain integers
   int m_cnt;
   int m_snap [NF];
   int m_disp [NF];
   bit m_valid;
   bit m_hit_d;
   int m_col_d;
   int mdl_addr, mdl_col;
   bit mdl_hit;

   function automatic void render(input int x, input int y, output int addr, output bit h, output int col);
      int fx, fy, c, r, p, cd;
      addr = 32 * 16;
      h    = 1'b0;
      col  = 0;
      for (int i = 0; i < NF; i++) begin
         fx = int'(field_x[i]);
         fy = int'(field_y[i]);
         if (!h && x >= fx && x < fx + 40 && y >= fy && y < fy + 16) begin
            h   = 1'b1;
            c   = (x - fx) / 8;
            col = (x - fx) % 8;
            r   = y - fy;
            if (c == 0) cd = 36;
            else begin
               p  = 10 ** (DG - c);
               cd = 48 + (m_disp[i] / p) % 10;
`ifdef MONEY_LEADING_ZERO_BLANK_EN
               if (c < DG && m_disp[i] < p) cd = 32;
`endif
            end
            addr = cd * 16 + r;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt   = 0;
         m_valid = 1'b0;
         m_hit_d = 1'b0;
         m_col_d = 0;
         for (int i = 0; i < NF; i++) begin
            m_disp[i] = 0;
            m_snap[i] = 0;
         end
      end else begin
         if (m_cnt == LAT)
            for (int i = 0; i < NF; i++)
               m_snap[i] = (int'(values[i]) > 9999) ? 9999 : int'(values[i]);
         if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_disp  = m_snap;
               m_valid = 1'b1;
            end
         end else if (frame_start) begin
            m_cnt = LAT;
         end
         render(int'(draw_x), int'(draw_y), mdl_addr, mdl_hit, mdl_col);
         m_hit_d = mdl_hit;
         m_col_d = mdl_col;
      end
   end

   bit    lit_en;
   int    lit_sel, lit_exp;
   string lit_nm;
   int    e_addr, e_col;
   bit    e_hit, e_text, e_busy, e_valid, e_ovr;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         e_addr = 0; e_text = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_ovr = 1'b0;
      end else begin
         render(int'(draw_x), int'(draw_y), e_addr, e_hit, e_col);
         e_text  = m_hit_d && font_data[7 - m_col_d];
         e_busy  = (m_cnt > 0);
         e_valid = m_valid;
         e_ovr   = frame_start && (m_cnt > 0);
      end
      chk("cyc_font_address", int'(font_address), e_addr);
      chk("cyc_text_on", int'(text_on), int'(e_text));
      chk("cyc_busy", int'(busy), int'(e_busy));
      chk("cyc_digits_valid", int'(digits_valid), int'(e_valid));
      chk("cyc_overrun", int'(overrun), int'(e_ovr));
      if (lit_en) begin
         case (lit_sel)
            0: chk(lit_nm, int'(font_address), lit_exp);
            1: chk(lit_nm, int'(font_address_14), lit_exp);
            2: chk(lit_nm, int'(text_on), lit_exp);
            3: chk(lit_nm, int'(overrun), lit_exp);
            4: chk(lit_nm, int'(busy), lit_exp);
            5: chk(lit_nm, int'(digits_valid), lit_exp);
            6: chk(lit_nm, int'(busy_14), lit_exp);
            7: chk(lit_nm, int'(digits_valid_14), lit_exp);
            8: chk(lit_nm, int'(text_on_14) + 2 * int'(overrun_14), lit_exp);
            default: ;
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(input string nm, input int sel, input int exp);
      lit_nm  = nm;
      lit_sel = sel;
      lit_exp = exp;
      lit_en  = 1'b1;
      @(negedge clk);
      #1;
      lit_en = 1'b0;
      tick(1);
   endtask

   task automatic probe(input string nm, input int sel, input int f, input int c, input int r, input int cd);
      draw_x = 10'(int'(field_x[f]) + 8 * c + 1);
      draw_y = 10'(int'(field_y[f]) + r);
      lit(nm, sel, cd * 16 + r);
   endtask

   task automatic place_default();
      field_x[0] = 10'd100; field_y[0] = 10'd50;
      field_x[1] = 10'd300; field_y[1] = 10'd50;
      field_x[2] = 10'd500; field_y[2] = 10'd50;
      field_x[3] = 10'd620; field_y[3] = 10'd470;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; values = '0; values14 = '0;
      font_data = 8'd0; draw_x = '0; draw_y = '0;
      lit_en = 1'b0; lit_sel = 0; lit_exp = 0; lit_nm = "";
      place_default();
      values14[1] = 14'd12000; values14[2] = 14'd5; values14[3] = 14'd16383;
      tick(2);

      draw_x = 10'd132; draw_y = 10'd53;
      lit("rst_addr", 0, 0);
      lit("rst_busy", 4, 0);
      lit("rst_valid", 5, 0);
      lit("rst_text", 2, 0);
      rst_n = 1'b1;
      probe("pre_d4", 0, 0, 4, 3, 48);
      probe("pre_d1", 0, 0, 1, 3, ZC);

      values[0] = 11'd1234; values[1] = 11'd0; values[2] = 11'd999; values[3] = 11'd2047;
      pulse_frame();
      tick(48);
      lit("busy_e49", 4, 1);
      lit("busy_e50", 4, 1);
      lit("busy_done", 4, 0);
      lit("valid_set", 5, 1);
      probe("f0_dollar", 0, 0, 0, 5, 36);
      probe("f0_d1", 0, 0, 1, 5, 49);
      probe("f0_d2", 0, 0, 2, 5, 50);
      probe("f0_d3", 0, 0, 3, 5, 51);
      probe("f0_d4", 0, 0, 4, 5, 52);
      probe("f1_d4", 0, 1, 4, 0, 48);
      probe("f1_d1", 0, 1, 1, 0, ZC);
      probe("f2_d1", 0, 2, 1, 15, ZC);
      probe("f2_d2", 0, 2, 2, 15, 57);
      probe("f3_d1", 0, 3, 1, 9, 50);
      probe("f3_d2", 0, 3, 2, 9, 48);
      draw_x = 10'd99; draw_y = 10'd55;
      lit("left_miss", 0, 32 * 16);

      values[0] = 11'd5;
      pulse_frame();
      tick(10);
      values[0] = 11'd1999;
      tick(9);
      frame_start = 1'b1;
      lit("overrun", 3, 1);
      frame_start = 1'b0;
      tick(30);
      probe("snap_d4", 0, 0, 4, 2, 53);
      probe("snap_d1", 0, 0, 1, 2, ZC);
      pulse_frame();
      tick(LAT);
      probe("next_d1", 0, 0, 1, 2, 49);
      probe("next_d2", 0, 0, 2, 2, 57);

      field_x[1] = 10'd100; field_y[1] = 10'd50;
      draw_x = 10'd115; draw_y = 10'd55;
      lit("overlap_addr", 0, 49 * 16 + 5);
      font_data = 8'h01;
      lit("overlap_text1", 2, 1);
      font_data = 8'h80;
      lit("overlap_text0", 2, 0);
      font_data = 8'h00;
      place_default();

      pulse_frame();
      tick(24);
      rst_n = 1'b0;
      lit("mid_rst_busy", 4, 0);
      lit("mid_rst_valid", 5, 0);
      rst_n = 1'b1;
      probe("mid_rst_d4", 0, 0, 4, 0, 48);
      probe("mid_rst_d1", 0, 0, 1, 0, ZC);
      pulse_frame();
      tick(LAT);
      lit("reconv_valid", 5, 1);
      probe("reconv_d1", 0, 0, 1, 0, 49);

      for (int n = 0; n < 3000; n++) begin
         int f, v;
         if ($urandom_range(0, 199) == 0)
            for (int i = 0; i < NF; i++) begin
               field_x[i] = 10'($urandom_range(0, 639));
               field_y[i] = 10'($urandom_range(0, 479));
            end
         if ($urandom_range(0, 9) == 0) begin
            f = int'($urandom_range(0, NF - 1));
            values[f] = VW'($urandom_range(0, 2047));
         end
         frame_start = ($urandom_range(0, 39) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
         if ($urandom_range(0, 1) == 0) begin
            f = int'($urandom_range(0, NF - 1));
            v = int'(field_x[f]) + int'($urandom_range(0, 48)) - 4;
            draw_x = 10'((v < 0) ? 0 : v);
            v = int'(field_y[f]) + int'($urandom_range(0, 20)) - 2;
            draw_y = 10'((v < 0) ? 0 : v);
         end else begin
            draw_x = 10'($urandom_range(0, 639));
            draw_y = 10'($urandom_range(0, 479));
         end
         font_data = 8'($urandom);
         tick(1);
      end
      frame_start = 1'b0;
      rst_n = 1'b1;

      place_default();
      font_data = 8'h00;
      tick(70);
      pulse_frame();
      tick(10);
      lit("busy14", 6, 1);
      tick(LAT14);
      lit("valid14", 7, 1);
      probe("clamp_d1", 1, 1, 1, 4, 57);
      probe("clamp_d2", 1, 1, 2, 4, 57);
      probe("clamp_d3", 1, 1, 3, 4, 57);
      probe("clamp_d4", 1, 1, 4, 4, 57);
      probe("clamp_max_d1", 1, 3, 1, 7, 57);
      probe("small14_d4", 1, 2, 4, 1, 53);
      lit("idle14_text_ovr", 8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/money_field_renderer.md
Name: money_field_renderer

Overview:
- Parametrised successor to the fixed-layout money text overlay.
- Renders NUM_FIELDS dollar amounts ("$" followed by DIGITS decimal digits) at runtime-programmable screen positions.
- Replaces per-pixel combinational divide/modulo with one shared sequential double-dabble converter. The converter runs once per frame and commits all fields to a display bank atomically.
- Sits between game state (stacks, pots) and the font ROM/colour mapper. The font ROM is assumed synchronous, with 1-cycle read latency.

Parameters:
- NUM_FIELDS, 4, number of independent money fields.
- VALUE_W, 11, width of each input value in bits.
- DIGITS, 4, decimal digits rendered per field (field width = (DIGITS+1)*8 px).

Ports:
- Clk  in  1  pixel/system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse at start of vertical blank; triggers snapshot and conversion.
- values  in  NUM_FIELDS x VALUE_W  unsigned amounts to display.
- field_x  in  NUM_FIELDS x 10  left pixel column of each field.
- field_y  in  NUM_FIELDS x 10  top pixel row of each field.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- font_data  in  8  font ROM row, valid one cycle after font_address.
- font_address  out  11  font ROM address: char code * 16 + row.
- text_on  out  1  foreground pixel, aligned with font_data (DrawX/DrawY of cycle t -> text_on at cycle t+1).
- busy  out  1  conversion in progress.
- digits_valid  out  1  at least one commit has occurred since reset.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Reset (async, Reset_n=0):
  - FSM to IDLE.
  - Display bank, shadow values and BCD registers cleared to 0.
  - text_on=0, font_address=0, busy=0, digits_valid=0, overrun=0.
  - While digits_valid=0, fields render as all-zero digits.
- FSM states:
  - IDLE: frame_start -> SNAP.
  - SNAP (1 cycle): latch all values into shadow registers, each clamped to min(value, 10^DIGITS-1); field index=0; -> LOAD.
  - LOAD (1 cycle): BCD register (DIGITS*4 bits)=0; shift register=shadow[index]; bit counter=VALUE_W; -> SHIFT.
  - SHIFT (VALUE_W cycles): each cycle, add 3 to every BCD nibble >=5, then shift {BCD,bin} left 1 and decrement the counter. At counter 0, write the BCD result into the staging bank at [index]. If index==NUM_FIELDS-1 -> COMMIT, else index+1 and -> LOAD.
  - COMMIT (1 cycle): copy staging bank to display bank in a single cycle; digits_valid<=1; -> IDLE.
- busy=1 in every state except IDLE.
- Latency from frame_start to display update = 1 + NUM_FIELDS*(VALUE_W+1) + 1 cycles (defaults: 50). The display bank changes only on the COMMIT edge, so no partially updated frame is ever shown.
- frame_start while busy: ignored (no restart, no re-snapshot); overrun pulses high for that cycle.
- values changing after SNAP: no effect until the next frame_start.
- Render path (combinational address, registered hit):
  - Field i is hit when field_x[i] <= DrawX < field_x[i]+(DIGITS+1)*8 and field_y[i] <= DrawY < field_y[i]+16.
  - Lowest-index hit wins on overlap.
  - char = (DrawX-field_x[i])>>3, row = DrawY-field_y[i].
  - char 0 -> '$' (36); char k>0 -> '0'+digit[k-1], most significant digit first.
  - No hit -> font_address = space (32)*16, hit_d=0.
  - Register hit_d and col_d=(DrawX-field_x[i])&7. text_on = hit_d & font_data[7-col_d].
- Field extending past column 639 or row 479: clipped naturally, no wrap. Comparisons use 11-bit sums so field_x+width does not overflow.
- Reset asserted mid-conversion: conversion abandoned, display bank zeroed; the next frame_start starts a fresh conversion.

Optional Feature:
- Macro: MONEY_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits render as space (code 32). The least significant digit always renders, so value 0 shows "$   0" and value 42 shows "$  42". Blanking is evaluated from the display bank at render time; the conversion FSM is unchanged.
- Undefined: all DIGITS digits render with leading zeros ("$0042").

Test Plan:
- Reset, then frame_start with values={1234,0,999,2047} -> busy high for 50 cycles (defaults), then digits_valid=1. Scanning field 0 issues font_address 36*16+row, then 49,50,51,52 (*16+row).
- Change values[0] from 5 to 1999 at frame_start+10 -> field 0 still shows 0005 after commit; shows 1999 only after the next frame_start.
- frame_start pulsed again 20 cycles after the first -> overrun=1 for that cycle; commit occurs at the original cycle 50 with the first snapshot.
- VALUE_W=14, values[1]=12000 -> field 1 renders 9999 (clamped).
- field_x[0]=field_x[1]=100, field_y both 200, different values -> field 0 glyphs displayed. Pixel at DrawX=100+8+7 (col 7 of digit 1) with font_data=8'h01 -> text_on=1 one cycle later.
- Reset_n pulsed low at cycle 25 of a conversion -> busy=0, digits_valid=0, all fields render 0000 (or "   0" with MONEY_LEADING_ZERO_BLANK_EN); the next frame_start converts normally.
